led_mode_sequencer: RTL and testbench
=====================================

# led_mode_sequencer

Sequences the 4-bit board LED bank from the two pushbuttons and the enable DIP switch. Raw buttons are synchronized and debounced. pb[0] steps through four display modes and pb[1] pauses or resumes animation. Sits between the board I/O pins and the LED outputs, replacing direct button-to-LED decoding with a debounced, timed mode controller.

## Interface
- DEBOUNCE_CYC, 500000: consecutive stable cycles required to accept a button level change (≥2).
- TICK_DIV, 12500000: clock cycles per animation step (≥2).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- dip  in  1  enable; 0 forces mode OFF.
- pb  in  2  raw, asynchronous, active-high buttons; pb[0] = mode step, pb[1] = pause toggle.
- LED  out  4  registered LED drive.
- mode  out  2  current mode: 00 OFF, 01 ALL, 10 BLINK, 11 CHASE.
- paused  out  1  animation frozen.

## Operation
- Reset values: LED=0000, mode=00, paused=0, tick counter=0, debounce counters=0, stable button levels=0.
- Per button: 2-flop synchronizer, then debounce counter.
  - synced == stable: counter clears to 0.
  - Otherwise counter increments. On the DEBOUNCE_CYC-th consecutive mismatch cycle, stable takes synced and the counter clears.
  - Press pulse = stable & ~stable_q. It is 1 cycle wide and occurs only on a 0→1 change of stable. Releases generate nothing.
- Mode FSM (advances on step press while dip=1): OFF→ALL→BLINK→CHASE→OFF (wraps).
  - Entry to any mode: paused←0, tick counter←0.
  - OFF: LED=0000.
  - ALL: LED=1111.
  - BLINK: entry LED=1100; each tick swaps 1100↔0011.
  - CHASE: entry LED=0001; each tick rotates left (0001→0010→0100→1000→0001).
- Tick counter: runs only in BLINK/CHASE with paused=0. Counts 0..TICK_DIV-1. Tick asserts on count==TICK_DIV-1, then the counter wraps to 0. Held (not cleared) while paused.
- Pause press toggles paused only in BLINK/CHASE. In OFF/ALL it is ignored and paused stays 0. While paused, LED holds its value.
- Simultaneous step and pause press in one cycle: step wins (mode advances, paused=0).
- dip=0 (sampled synchronously):
  - Next edge: mode←OFF, LED←0000, paused←0, tick counter←0.
  - All presses are ignored, but debouncers keep tracking.
  - On dip 0→1, mode stays OFF until the next step press.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). On release, operation resumes from OFF with no press generated unless a button is already held and subsequently debounced high.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Raw pb going high and staying high: stable rises DEBOUNCE_CYC+2 edges after the first edge sampling it high. Press pulse is active the following cycle. mode/LED/paused update on the edge ending the pulse cycle, giving DEBOUNCE_CYC+3 edges total.
- Glitch shorter than DEBOUNCE_CYC synced cycles: no stable change, no press.
- In BLINK/CHASE unpaused: LED changes every TICK_DIV cycles exactly. The first change is TICK_DIV cycles after the entry edge.
- Pause then resume: the remaining time to the next tick equals the remaining time at the pause instant.
- dip→OFF latency: 1 edge after dip is sampled low (dip is not synchronized or debounced; it is treated as quasi-static).

## Test plan
(DEBOUNCE_CYC=4, TICK_DIV=3 for all scenarios.)
- Reset: hold rst_n=0 with pb toggling → LED=0000, mode=00, paused=0. Release, dip=1 and no press → outputs unchanged for 50 cycles.
- Debounce:
  - pb[0] high 3 cycles then low → no mode change.
  - pb[0] held high → mode=01 and LED=1111 exactly 7 edges after first sample.
  - Hold pb[0] 100 cycles → single advance only.
- Mode walk: four clean step presses → mode 01,10,11,00. In BLINK, LED alternates 1100/0011 every 3 cycles. In CHASE, 0001,0010,0100,1000,0001 every 3 cycles. OFF gives LED=0000.
- Pause:
  - In CHASE at LED=0010 one cycle after a tick, press pb[1] → LED frozen at 0010 for 20 cycles.
  - Press pb[1] again → next change to 0100 occurs 2 cycles after resume.
  - In ALL, press pb[1] → paused stays 0.
- Simultaneous: step and pause presses debounced in the same cycle while in BLINK → mode=11, LED=0001, paused=0.
- Disable: in CHASE, dip=0 → next edge mode=00, LED=0000; step presses while dip=0 ignored. dip=1 then one step press → mode=01, LED=1111.

Source files
------------

// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - debounced pushbutton mode sequencer for the 4-bit LED bank
module led_mode_sequencer #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int TICK_DIV     = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dip,
    input  logic [1:0] pb,
    output logic [3:0] LED,
    output logic [1:0] mode,
    output logic       paused
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC);
    localparam int TK_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        M_OFF   = 2'b00,
        M_ALL   = 2'b01,
        M_BLINK = 2'b10,
        M_CHASE = 2'b11
    } mode_e;

    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      stable_q;
    logic [1:0]      stable_prev_q;
    logic [DB_W-1:0] db_cnt_q [2];

    mode_e           mode_q;
    logic [3:0]      led_q;
    logic            paused_q;
    logic [TK_W-1:0] tick_cnt_q;

    logic [1:0] press;
    logic       step_press;
    logic       pause_press;
    logic       anim_mode;
    logic [3:0] led_step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q       <= pb;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_MAX) begin
                    stable_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press       = stable_q & ~stable_prev_q;
    assign step_press  = press[0];
    assign pause_press = press[1];
    assign anim_mode   = (mode_q == M_BLINK) || (mode_q == M_CHASE);

    // BLINK pattern 1100/0011 is a pure inversion; CHASE rotates left
    always_comb begin
        led_step_d = led_q;
        if (mode_q == M_BLINK) led_step_d = ~led_q;
        else if (mode_q == M_CHASE) led_step_d = {led_q[2:0], led_q[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= M_OFF;
            led_q      <= 4'b0000;
            paused_q   <= 1'b0;
            tick_cnt_q <= '0;
        end else if (!dip) begin
            mode_q     <= M_OFF;
            led_q      <= 4'b0000;
            paused_q   <= 1'b0;
            tick_cnt_q <= '0;
        end else if (step_press) begin
            paused_q   <= 1'b0;
            tick_cnt_q <= '0;
            case (mode_q)
                M_OFF:   begin mode_q <= M_ALL;   led_q <= 4'b1111; end
                M_ALL:   begin mode_q <= M_BLINK; led_q <= 4'b1100; end
                M_BLINK: begin mode_q <= M_CHASE; led_q <= 4'b0001; end
                default: begin mode_q <= M_OFF;   led_q <= 4'b0000; end
            endcase
        end else if (pause_press && anim_mode) begin
            // tick counter is held so resume keeps the remaining interval
            paused_q <= ~paused_q;
        end else if (anim_mode && !paused_q) begin
            if (tick_cnt_q == TK_MAX) begin
                tick_cnt_q <= '0;
                led_q      <= led_step_d;
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end
        end
    end

    assign LED    = led_q;
    assign mode   = mode_q;
    assign paused = paused_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - directed vector bench for led_mode_sequencer
module tb_led_mode_sequencer;

    logic       clk;
    logic       rst_n;
    logic       dip;
    logic [1:0] pb;
    logic [3:0] LED;
    logic [1:0] mode;
    logic       paused;

    int checks;
    int errors;

    led_mode_sequencer #(
        .DEBOUNCE_CYC(4),
        .TICK_DIV    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dip   (dip),
        .pb    (pb),
        .LED   (LED),
        .mode  (mode),
        .paused(paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dip;
        logic [1:0] pb;
        int         adv;
        logic [1:0] exp_mode;
        logic [3:0] exp_led;
        logic       exp_paused;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string name, input logic [1:0] m, input logic [3:0] l, input logic p);
        chk({name, ".mode"}, 32'(mode), 32'(m));
        chk({name, ".led"}, 32'(LED), 32'(l));
        chk({name, ".paused"}, 32'(paused), 32'(p));
    endtask

    task automatic press_release(input logic [1:0] b);
        pb = b;
        adv(7);
        pb = 2'b00;
        adv(8);
    endtask

    initial begin
        int bad;
        checks = 0;
        errors = 0;

        vt[0]  = '{1'b1, 2'b01, 7, 2'b10, 4'b1100, 1'b0};
        vt[1]  = '{1'b1, 2'b01, 2, 2'b10, 4'b1100, 1'b0};
        vt[2]  = '{1'b1, 2'b01, 1, 2'b10, 4'b0011, 1'b0};
        vt[3]  = '{1'b1, 2'b01, 3, 2'b10, 4'b1100, 1'b0};
        vt[4]  = '{1'b1, 2'b00, 8, 2'b10, 4'b1100, 1'b0};
        vt[5]  = '{1'b1, 2'b01, 7, 2'b11, 4'b0001, 1'b0};
        vt[6]  = '{1'b1, 2'b01, 3, 2'b11, 4'b0010, 1'b0};
        vt[7]  = '{1'b1, 2'b01, 3, 2'b11, 4'b0100, 1'b0};
        vt[8]  = '{1'b1, 2'b01, 3, 2'b11, 4'b1000, 1'b0};
        vt[9]  = '{1'b1, 2'b01, 3, 2'b11, 4'b0001, 1'b0};
        vt[10] = '{1'b1, 2'b00, 8, 2'b11, 4'b0100, 1'b0};
        vt[11] = '{1'b1, 2'b01, 7, 2'b00, 4'b0000, 1'b0};
        vt[12] = '{1'b1, 2'b00, 8, 2'b00, 4'b0000, 1'b0};
        vt[13] = '{1'b1, 2'b01, 7, 2'b01, 4'b1111, 1'b0};
        vt[14] = '{1'b1, 2'b00, 8, 2'b01, 4'b1111, 1'b0};
        vt[15] = '{1'b1, 2'b10, 7, 2'b01, 4'b1111, 1'b0};
        vt[16] = '{1'b1, 2'b00, 8, 2'b01, 4'b1111, 1'b0};

        // reset held with buttons toggling
        rst_n = 1'b0;
        dip   = 1'b0;
        pb    = 2'b00;
        for (int i = 0; i < 6; i++) begin
            pb = 2'(i);
            adv(1);
        end
        chk_out("reset", 2'b00, 4'b0000, 1'b0);
        pb = 2'b00;
        adv(2);
        rst_n = 1'b1;
        dip   = 1'b1;
        bad   = 0;
        for (int i = 0; i < 50; i++) begin
            adv(1);
            if (LED !== 4'b0000 || mode !== 2'b00 || paused !== 1'b0) bad++;
        end
        chk("idle50", 32'(bad), 32'd0);

        // glitch of three cycles is rejected
        pb = 2'b01;
        adv(3);
        pb = 2'b00;
        adv(10);
        chk_out("glitch", 2'b00, 4'b0000, 1'b0);

        // held press lands on the seventh edge, and only once
        pb = 2'b01;
        adv(6);
        chk("deb_edge6.mode", 32'(mode), 32'd0);
        adv(1);
        chk_out("deb_edge7", 2'b01, 4'b1111, 1'b0);
        adv(100);
        chk_out("hold100", 2'b01, 4'b1111, 1'b0);
        pb = 2'b00;
        adv(8);

        for (int i = 0; i < 17; i++) begin
            dip = vt[i].dip;
            pb  = vt[i].pb;
            adv(vt[i].adv);
            chk_out($sformatf("vec%0d", i), vt[i].exp_mode, vt[i].exp_led, vt[i].exp_paused);
        end

        // pause in CHASE one cycle after the 0001->0010 tick
        press_release(2'b01);
        chk("to_blink.mode", 32'(mode), 32'd2);
        pb = 2'b01;
        adv(5);
        pb = 2'b11;
        adv(2);
        chk_out("chase_entry", 2'b11, 4'b0001, 1'b0);
        adv(5);
        chk_out("pause_on", 2'b11, 4'b0010, 1'b1);
        pb  = 2'b00;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            adv(1);
            if (LED !== 4'b0010 || paused !== 1'b1) bad++;
        end
        chk("frozen20", 32'(bad), 32'd0);
        pb = 2'b10;
        adv(7);
        chk_out("resume", 2'b11, 4'b0010, 1'b0);
        adv(1);
        chk("resume+1.led", 32'(LED), 32'b0010);
        adv(1);
        chk("resume+2.led", 32'(LED), 32'b0100);
        pb = 2'b00;
        adv(8);

        // step and pause debounced together in BLINK
        press_release(2'b01);
        press_release(2'b01);
        press_release(2'b01);
        chk("pre_simul.mode", 32'(mode), 32'd2);
        pb = 2'b11;
        adv(7);
        chk_out("simul", 2'b11, 4'b0001, 1'b0);
        pb = 2'b00;
        adv(8);

        // dip disable
        dip = 1'b0;
        adv(1);
        chk_out("dip_off", 2'b00, 4'b0000, 1'b0);
        press_release(2'b01);
        chk_out("dip_off_press", 2'b00, 4'b0000, 1'b0);
        dip = 1'b1;
        adv(2);
        chk("dip_on.mode", 32'(mode), 32'd0);
        pb = 2'b01;
        adv(7);
        chk_out("dip_on_press", 2'b01, 4'b1111, 1'b0);
        pb = 2'b00;
        adv(8);

        // asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 2'b00, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        adv(5);
        chk_out("post_rst", 2'b00, 4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
